// File: rtl/branch_predictor_if.sv
// Pipeline-facing bundle for the branch predictor: IF-stage lookup, MEM-stage
// resolution/training, mispredict redirect and statistics.
interface branch_predictor_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
);
  logic              lookup_pc_dummy_unused;
  logic [ADDR_W-1:0] lookup_pc;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;

  logic              update_valid;
  logic [ADDR_W-1:0] update_pc;
  logic              update_is_jump;
  logic              update_taken;
  logic [ADDR_W-1:0] update_target;
  logic              update_pred_taken;
  logic [ADDR_W-1:0] update_pred_target;
  logic              invalidate;

  logic              mispredict;
  logic [ADDR_W-1:0] redirect_pc;
  logic [CNT_W-1:0]  branch_cnt;
  logic [CNT_W-1:0]  mispredict_cnt;

  assign lookup_pc_dummy_unused = 1'b0;

  modport master (
    output lookup_pc, update_valid, update_pc, update_is_jump, update_taken,
           update_target, update_pred_taken, update_pred_target, invalidate,
    input  pred_taken, pred_target, mispredict, redirect_pc, branch_cnt,
           mispredict_cnt
  );

  modport slave (
    input  lookup_pc, update_valid, update_pc, update_is_jump, update_taken,
           update_target, update_pred_taken, update_pred_target, invalidate,
    output pred_taken, pred_target, mispredict, redirect_pc, branch_cnt,
           mispredict_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters,
// MEM-stage training, mispredict redirect and saturating statistics counters.
module branch_predictor #(
  parameter int         ENTRIES  = 16,
  parameter int         ADDR_W   = 32,
  parameter logic [1:0] CTR_INIT = 2'b01,
  parameter int         CNT_W    = 32
) (
  input logic          clock,
  input logic          reset,
  branch_predictor_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [ENTRIES-1:0] valid;
  logic [ENTRIES-1:0] jmp;
  logic [TAG_W-1:0]   tag    [ENTRIES];
  logic [ADDR_W-1:0]  target [ENTRIES];
  logic [1:0]         ctr    [ENTRIES];
  logic [CNT_W-1:0]   branch_cnt;
  logic [CNT_W-1:0]   mispredict_cnt;

  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [TAG_W-1:0] up_tag;
  logic             lk_hit;
  logic             up_hit;
  logic             lk_taken;
  logic             mispredict;
  logic             unused_bits;

  assign lk_idx = bus.lookup_pc[IDX_W+1:2];
  assign lk_tag = bus.lookup_pc[ADDR_W-1:IDX_W+2];
  assign up_idx = bus.update_pc[IDX_W+1:2];
  assign up_tag = bus.update_pc[ADDR_W-1:IDX_W+2];
  assign unused_bits = ^bus.lookup_pc[1:0];

  // Lookup reads the registered table only, so a same-cycle update is not visible.
  assign lk_hit   = valid[lk_idx] && (tag[lk_idx] == lk_tag);
  assign up_hit   = valid[up_idx] && (tag[up_idx] == up_tag);
  assign lk_taken = lk_hit && (jmp[lk_idx] || ctr[lk_idx][1]);

  assign bus.pred_taken  = lk_taken;
  assign bus.pred_target = lk_taken ? target[lk_idx] : '0;

  assign mispredict = bus.update_valid &&
                      ((bus.update_taken != bus.update_pred_taken) ||
                       (bus.update_taken && (bus.update_target != bus.update_pred_target)));
  assign bus.mispredict     = mispredict;
  assign bus.redirect_pc    = bus.update_taken ? bus.update_target
                                               : bus.update_pc + ADDR_W'(4);
  assign bus.branch_cnt     = branch_cnt;
  assign bus.mispredict_cnt = mispredict_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid          <= '0;
      jmp            <= '0;
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag[i]    <= '0;
        target[i] <= '0;
        ctr[i]    <= CTR_INIT;
      end
    end else begin
      if (bus.update_valid && (branch_cnt != '1))
        branch_cnt <= branch_cnt + CNT_W'(1);
      if (mispredict && (mispredict_cnt != '1))
        mispredict_cnt <= mispredict_cnt + CNT_W'(1);

      // Invalidate wins over training; the statistics above still see the update.
      if (bus.invalidate) begin
        valid <= '0;
      end else if (bus.update_valid) begin
        if (up_hit) begin
          if (bus.update_is_jump) begin
            ctr[up_idx]    <= 2'b11;
            target[up_idx] <= bus.update_target;
            jmp[up_idx]    <= 1'b1;
          end else begin
            if (bus.update_taken) begin
              if (ctr[up_idx] != 2'b11)
                ctr[up_idx] <= ctr[up_idx] + 2'd1;
              target[up_idx] <= bus.update_target;
            end else if (ctr[up_idx] != 2'b00) begin
              ctr[up_idx] <= ctr[up_idx] - 2'd1;
            end
            jmp[up_idx] <= 1'b0;
          end
        end else if (bus.update_taken) begin
          valid[up_idx]  <= 1'b1;
          tag[up_idx]    <= up_tag;
          target[up_idx] <= bus.update_target;
          jmp[up_idx]    <= bus.update_is_jump;
          ctr[up_idx]    <= bus.update_is_jump ? 2'b11 : 2'b10;
        end
      end
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vectors with literal
// expectations plus a per-cycle comparison against a table-level model.
module tb_branch_predictor;
  localparam int ENTRIES = 16;
  localparam int ADDR_W  = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  branch_predictor_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus();

  branch_predictor #(
    .ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .CTR_INIT(2'b01), .CNT_W(CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  // Model: one record per table slot, counter held as a plain integer 0..3.
  bit              m_valid  [ENTRIES];
  bit              m_jmp    [ENTRIES];
  longint unsigned m_tag    [ENTRIES];
  longint unsigned m_target [ENTRIES];
  int              m_ctr    [ENTRIES];
  int              m_branches;
  int              m_mispredicts;

  function automatic int idx_of(longint unsigned pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic longint unsigned tag_of(longint unsigned pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic bit model_hit(longint unsigned pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit model_taken(longint unsigned pc);
    return model_hit(pc) && (m_jmp[idx_of(pc)] || (m_ctr[idx_of(pc)] >= 2));
  endfunction

  function automatic longint unsigned model_target(longint unsigned pc);
    return model_taken(pc) ? m_target[idx_of(pc)] : 0;
  endfunction

  function automatic bit model_mispredict();
    if (!bus.update_valid) return 1'b0;
    if (bus.update_taken != bus.update_pred_taken) return 1'b1;
    return bus.update_taken && (bus.update_target != bus.update_pred_target);
  endfunction

  function automatic longint unsigned model_redirect();
    if (bus.update_taken) return 64'(bus.update_target);
    return (64'(bus.update_pc) + 4) % (64'd1 << ADDR_W);
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i]  = 1'b0;
        m_jmp[i]    = 1'b0;
        m_tag[i]    = 0;
        m_target[i] = 0;
        m_ctr[i]    = 1;
      end
      m_branches    = 0;
      m_mispredicts = 0;
    end else begin
      int              ui;
      longint unsigned upc;
      upc = 64'(bus.update_pc);
      ui  = idx_of(upc);
      if (bus.update_valid && m_branches < CNT_MAX) m_branches++;
      if (model_mispredict() && m_mispredicts < CNT_MAX) m_mispredicts++;
      if (bus.invalidate) begin
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
      end else if (bus.update_valid) begin
        if (model_hit(upc) && bus.update_is_jump) begin
          m_ctr[ui]    = 3;
          m_target[ui] = 64'(bus.update_target);
          m_jmp[ui]    = 1'b1;
        end else if (model_hit(upc)) begin
          if (bus.update_taken) begin
            m_ctr[ui]    = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
            m_target[ui] = 64'(bus.update_target);
          end else begin
            m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
          end
          m_jmp[ui] = bus.update_is_jump;
        end else if (bus.update_taken) begin
          m_valid[ui]  = 1'b1;
          m_tag[ui]    = tag_of(upc);
          m_target[ui] = 64'(bus.update_target);
          m_jmp[ui]    = bus.update_is_jump;
          m_ctr[ui]    = bus.update_is_jump ? 3 : 2;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Outputs are stable mid-cycle, so compare against the model on every falling edge.
  always @(negedge clock) begin
    if (reset) begin
      checkOutput("model pred_taken", 64'(bus.pred_taken), 64'(model_taken(64'(bus.lookup_pc))));
      checkOutput("model pred_target", 64'(bus.pred_target), model_target(64'(bus.lookup_pc)));
      checkOutput("model mispredict", 64'(bus.mispredict), 64'(model_mispredict()));
      if (model_mispredict())
        checkOutput("model redirect_pc", 64'(bus.redirect_pc), model_redirect());
      checkOutput("model branch_cnt", 64'(bus.branch_cnt), 64'(m_branches));
      checkOutput("model mispredict_cnt", 64'(bus.mispredict_cnt), 64'(m_mispredicts));
    end
  end

  task automatic applyStimulus(input logic uv, input logic [31:0] upc, input logic is_jump,
                               input logic taken, input logic [31:0] tgt, input logic ptaken,
                               input logic [31:0] ptgt, input logic inv);
    bus.update_valid       = uv;
    bus.update_pc          = upc;
    bus.update_is_jump     = is_jump;
    bus.update_taken       = taken;
    bus.update_target      = tgt;
    bus.update_pred_taken  = ptaken;
    bus.update_pred_target = ptgt;
    bus.invalidate         = inv;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic pulseReset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  initial begin
    idle();
    bus.lookup_pc = 32'h40;
    #2;
    checkOutput("reset pred_taken", 64'(bus.pred_taken), 64'd0);
    checkOutput("reset pred_target", 64'(bus.pred_target), 64'h0);
    checkOutput("reset branch_cnt", 64'(bus.branch_cnt), 64'd0);
    checkOutput("reset mispredict_cnt", 64'(bus.mispredict_cnt), 64'd0);
    #10;
    reset = 1'b1;

    // First taken branch allocates its entry.
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("alloc mispredict", 64'(bus.mispredict), 64'd1);
    checkOutput("alloc redirect_pc", 64'(bus.redirect_pc), 64'h100);
    checkOutput("no bypass pred_taken", 64'(bus.pred_taken), 64'd0);
    step();
    idle();
    #1;
    checkOutput("alloc pred_taken", 64'(bus.pred_taken), 64'd1);
    checkOutput("alloc pred_target", 64'(bus.pred_target), 64'h100);
    checkOutput("alloc branch_cnt", 64'(bus.branch_cnt), 64'd1);
    checkOutput("alloc mispredict_cnt", 64'(bus.mispredict_cnt), 64'd1);

    // Two not-taken outcomes walk the counter 10 -> 01 -> 00.
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
    #1;
    checkOutput("nt1 mispredict", 64'(bus.mispredict), 64'd1);
    checkOutput("nt1 redirect_pc", 64'(bus.redirect_pc), 64'h44);
    step();
    checkOutput("nt1 pred_taken", 64'(bus.pred_taken), 64'd0);
    checkOutput("nt2 redirect_pc", 64'(bus.redirect_pc), 64'h44);
    step();
    idle();
    #1;
    checkOutput("nt2 pred_taken", 64'(bus.pred_taken), 64'd0);
    checkOutput("nt2 branch_cnt", 64'(bus.branch_cnt), 64'd3);
    checkOutput("nt2 mispredict_cnt", 64'(bus.mispredict_cnt), 64'd3);
    pulseReset();

    // Aliasing: 0x80 shares index 0 with 0x40 but has a different tag.
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
    step();
    idle();
    #1;
    checkOutput("alias 0x40 taken", 64'(bus.pred_taken), 64'd1);
    bus.lookup_pc = 32'h80;
    #1;
    checkOutput("alias 0x80 miss", 64'(bus.pred_taken), 64'd0);
    applyStimulus(1'b1, 32'h80, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0);
    step();
    idle();
    bus.lookup_pc = 32'h40;
    #1;
    checkOutput("evicted 0x40", 64'(bus.pred_taken), 64'd0);
    bus.lookup_pc = 32'h80;
    #1;
    checkOutput("evictor 0x80 target", 64'(bus.pred_target), 64'h300);

    // Not-taken miss must not allocate.
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("nt miss mispredict", 64'(bus.mispredict), 64'd0);
    step();
    idle();
    bus.lookup_pc = 32'h10;
    #1;
    checkOutput("nt miss pred_taken", 64'(bus.pred_taken), 64'd0);

    // Jump install, then invalidate colliding with an update.
    applyStimulus(1'b1, 32'h8, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
    step();
    idle();
    bus.lookup_pc = 32'h8;
    #1;
    checkOutput("jump pred_taken", 64'(bus.pred_taken), 64'd1);
    checkOutput("jump pred_target", 64'(bus.pred_target), 64'h200);
    applyStimulus(1'b1, 32'h8, 1'b1, 1'b1, 32'h200, 1'b1, 32'h200, 1'b1);
    #1;
    checkOutput("inv mispredict", 64'(bus.mispredict), 64'd0);
    step();
    idle();
    #1;
    checkOutput("inv pred_taken", 64'(bus.pred_taken), 64'd0);
    checkOutput("inv branch_cnt", 64'(bus.branch_cnt), 64'd5);
    checkOutput("inv mispredict_cnt", 64'(bus.mispredict_cnt), 64'd3);
    pulseReset();

    // Statistics saturate at 15 with a 4-bit counter.
    for (int n = 0; n < 20; n++) begin
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b1, 32'h400, 1'b0, 32'h0, 1'b0);
      step();
    end
    idle();
    bus.lookup_pc = 32'h100;
    #1;
    checkOutput("sat branch_cnt", 64'(bus.branch_cnt), 64'd15);
    checkOutput("sat mispredict_cnt", 64'(bus.mispredict_cnt), 64'd15);
    checkOutput("sat pred_taken", 64'(bus.pred_taken), 64'd1);
    reset = 1'b0;
    #1;
    checkOutput("async branch_cnt", 64'(bus.branch_cnt), 64'd0);
    checkOutput("async mispredict_cnt", 64'(bus.mispredict_cnt), 64'd0);
    checkOutput("async pred_taken", 64'(bus.pred_taken), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
